// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the FIFO write-port arbiter
`timescale 1ns/1ps
package fifo_arb_pkg;

  // IDLE: arbitrating (one bubble cycle); OWN: winner streams its burst
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_BURST_MAX = 4;

  localparam int ID_W  = $clog2(DEF_N_REQ);
  localparam int CNT_W = $clog2(DEF_BURST_MAX + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin pick starting after last_winner
`timescale 1ns/1ps
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_winner,
  output logic [ID_W-1:0]  winner,
  output logic             any_req
);

  int   idx;
  logic found;

  // Scan last_winner+1 .. last_winner+N_REQ; wrap with an explicit compare so
  // non-power-of-two N_REQ never lands on a nonexistent requester.
  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_winner) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
`timescale 1ns/1ps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int GID_W  = $clog2(N_REQ);
  localparam int BCNT_W = $clog2(BURST_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [GID_W-1:0]  owner_q, owner_d;
  logic [GID_W-1:0]  last_q, last_d;
  logic [BCNT_W-1:0] beat_q, beat_d;

  logic [GID_W-1:0]  pick;
  logic              any_req;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (GID_W)
  ) u_rr_pick (
    .req         (req_valid),
    .last_winner (last_q),
    .winner      (pick),
    .any_req     (any_req)
  );

  // Next-state, burst beat counting and the write-port mux driven by the registered owner
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_d     = beat_q;
    req_ready  = '0;
    fifo_wen   = 1'b0;
    fifo_wdata = '0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = pick;
          beat_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        busy                = 1'b1;
        req_ready[owner_q]  = !fifo_full;
        fifo_wen            = req_valid[owner_q] & !fifo_full;
        for (int i = 0; i < N_REQ; i++) begin
          if (owner_q == GID_W'(i)) fifo_wdata = req_data[i*DATA_W +: DATA_W];
        end
        // req_last only counts on a beat that actually transfers
        if (fifo_wen) begin
          if (req_last[owner_q] || (beat_q == BCNT_W'(BURST_MAX - 1))) begin
            state_d = IDLE;
            last_d  = owner_q;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = owner_q;

  // State registers; last_q resets to N_REQ-1 so requester 0 wins the first scan
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= GID_W'(N_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BM = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wen;
  logic [DW-1:0]     fifo_wdata;
  logic [ID_W-1:0]   grant_id;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '1; req_last = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'h5A00 + 16'(i);
    #3;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    vectors++; if (fifo_wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen got=%0b exp=0", fifo_wen); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    vectors++; if (fifo_wdata !== 16'h0) begin miscompares++; $display("FAIL reset_wdata got=%h exp=0000", fifo_wdata); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    apply_reset();
  endtask

  task automatic test_first_grant();
    apply_reset();
    req_valid = 4'b0001; req_data[15:0] = 16'hA000; req_last = 4'b0000;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || fifo_wen !== 1'b0) begin miscompares++; $display("FAIL first_idle busy=%0b wen=%0b exp 0/0", busy, fifo_wen); end
    step();
    @(negedge clk);
    vectors++; if (fifo_wen !== 1'b1) begin miscompares++; $display("FAIL first_wen got=%0b exp=1", fifo_wen); end
    vectors++; if (fifo_wdata !== 16'hA000) begin miscompares++; $display("FAIL first_wdata got=%h exp=a000", fifo_wdata); end
    vectors++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin miscompares++; $display("FAIL first_grant ready=%b grant=%0d exp 0001/0", req_ready, grant_id); end
    step();
    req_data[15:0] = 16'hA001; req_last = 4'b0001;
    @(negedge clk);
    vectors++; if (fifo_wen !== 1'b1 || fifo_wdata !== 16'hA001) begin miscompares++; $display("FAIL first_beat2 wen=%0b wdata=%h exp 1/a001", fifo_wen, fifo_wdata); end
    step();
    req_valid = '0; req_last = '0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || fifo_wen !== 1'b0) begin miscompares++; $display("FAIL first_release busy=%0b wen=%0b exp 0/0", busy, fifo_wen); end
  endtask

  task automatic test_round_robin();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'hB000 + 16'(i);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_bubble%0d busy=%0b exp=0", g, busy); end
      step();
      @(negedge clk);
      vectors++; if (busy !== 1'b1 || grant_id !== 2'(exp_id[g])) begin miscompares++; $display("FAIL rr_grant%0d busy=%0b grant=%0d exp 1/%0d", g, busy, grant_id, exp_id[g]); end
      vectors++; if (fifo_wen !== 1'b1 || fifo_wdata !== 16'hB000 + 16'(exp_id[g])) begin miscompares++; $display("FAIL rr_write%0d wen=%0b wdata=%h exp 1/%h", g, fifo_wen, fifo_wdata, 16'hB000 + 16'(exp_id[g])); end
      step();
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_burst_cap();
    apply_reset();
    req_data[1*DW +: DW] = 16'hC100; req_last = 4'b0010;
    req_valid = 4'b0100;
    @(negedge clk);
    step();
    req_valid = 4'b0110;
    for (int k = 0; k < BM; k++) begin
      req_data[2*DW +: DW] = 16'hD000 + 16'(k);
      @(negedge clk);
      vectors++; if (grant_id !== 2'd2 || fifo_wen !== 1'b1 || fifo_wdata !== 16'hD000 + 16'(k)) begin miscompares++; $display("FAIL cap_beat%0d grant=%0d wen=%0b wdata=%h exp 2/1/%h", k, grant_id, fifo_wen, fifo_wdata, 16'hD000 + 16'(k)); end
      step();
    end
    req_data[2*DW +: DW] = 16'hD004;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cap_release busy=%0b exp=0", busy); end
    step();
    @(negedge clk);
    vectors++; if (grant_id !== 2'd1 || fifo_wdata !== 16'hC100 || fifo_wen !== 1'b1) begin miscompares++; $display("FAIL cap_next grant=%0d wdata=%h exp 1/c100", grant_id, fifo_wdata); end
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    vectors++; if (grant_id !== 2'd2 || fifo_wdata !== 16'hD004 || fifo_wen !== 1'b1) begin miscompares++; $display("FAIL cap_again grant=%0d wdata=%h exp 2/d004", grant_id, fifo_wdata); end
    step();
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 4'b0001; req_data[15:0] = 16'hE000;
    @(negedge clk);
    step();
    @(negedge clk);
    vectors++; if (fifo_wen !== 1'b1 || fifo_wdata !== 16'hE000) begin miscompares++; $display("FAIL bp_beat0 wen=%0b wdata=%h exp 1/e000", fifo_wen, fifo_wdata); end
    step();
    fifo_full = 1'b1; req_last = 4'b0001; req_data[15:0] = 16'hE001;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      vectors++; if (fifo_wen !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_stall%0d wen=%0b ready=%b busy=%0b exp 0/0000/1", s, fifo_wen, req_ready, busy); end
      step();
    end
    fifo_full = 1'b0; req_last = 4'b0000;
    for (int k = 1; k < BM; k++) begin
      req_data[15:0] = 16'hE000 + 16'(k);
      @(negedge clk);
      vectors++; if (fifo_wen !== 1'b1 || fifo_wdata !== 16'hE000 + 16'(k)) begin miscompares++; $display("FAIL bp_resume%0d wen=%0b wdata=%h exp 1/%h", k, fifo_wen, fifo_wdata, 16'hE000 + 16'(k)); end
      step();
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release busy=%0b exp=0", busy); end
    req_valid = '0;
  endtask

  task automatic test_owner_stall();
    apply_reset();
    req_valid = 4'b0001; req_data[15:0] = 16'hF000; req_data[3*DW +: DW] = 16'hF300;
    @(negedge clk);
    step();
    @(negedge clk);
    vectors++; if (fifo_wen !== 1'b1) begin miscompares++; $display("FAIL stall_beat0 wen=%0b exp=1", fifo_wen); end
    step();
    req_valid = 4'b1000;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_wen !== 1'b0 || req_ready !== 4'b0001) begin miscompares++; $display("FAIL stall_hold%0d busy=%0b grant=%0d wen=%0b ready=%b exp 1/0/0/0001", s, busy, grant_id, fifo_wen, req_ready); end
      step();
    end
    req_valid = 4'b1001; req_last = 4'b0001; req_data[15:0] = 16'hF001;
    @(negedge clk);
    vectors++; if (fifo_wen !== 1'b1 || fifo_wdata !== 16'hF001 || grant_id !== 2'd0) begin miscompares++; $display("FAIL stall_resume wen=%0b wdata=%h grant=%0d exp 1/f001/0", fifo_wen, fifo_wdata, grant_id); end
    step();
    req_valid = 4'b1000; req_last = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    vectors++; if (grant_id !== 2'd3 || fifo_wdata !== 16'hF300) begin miscompares++; $display("FAIL stall_next grant=%0d wdata=%h exp 3/f300", grant_id, fifo_wdata); end
    step();
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid = 4'b0001; req_last = 4'b0001; req_data[15:0] = 16'h1000; req_data[DW +: DW] = 16'h1100;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    req_valid = 4'b0011; req_last = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    vectors++; if (grant_id !== 2'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL ar_pre grant=%0d busy=%0b exp 1/1", grant_id, busy); end
    step();
    #2 rstn = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || fifo_wen !== 1'b0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL ar_drop busy=%0b wen=%0b ready=%b exp 0/0/0000", busy, fifo_wen, req_ready); end
    vectors++; if (fifo_wdata !== 16'h0 || grant_id !== 2'd0) begin miscompares++; $display("FAIL ar_drop_data wdata=%h grant=%0d exp 0000/0", fifo_wdata, grant_id); end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    vectors++; if (grant_id !== 2'd0 || fifo_wdata !== 16'h1000 || fifo_wen !== 1'b1) begin miscompares++; $display("FAIL ar_first grant=%0d wdata=%h wen=%0b exp 0/1000/1", grant_id, fifo_wdata, fifo_wen); end
    step();
    req_valid = '0;
  endtask

  task automatic test_random();
    bit           m_busy;
    int           m_owner, m_last, m_beats;
    logic [N-1:0] exp_ready;
    logic         exp_wen;
    logic [DW-1:0] exp_wdata;
    bit           found;
    apply_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_beats = 0;
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_last  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'($urandom);
      @(negedge clk);
      exp_ready = '0; exp_wen = 1'b0; exp_wdata = '0;
      if (m_busy) begin
        exp_ready[m_owner] = !fifo_full;
        exp_wen   = req_valid[m_owner] && !fifo_full;
        exp_wdata = req_data[m_owner*DW +: DW];
      end
      vectors++; if (busy !== 1'(m_busy)) begin miscompares++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_busy); end
      vectors++; if (fifo_wen !== exp_wen) begin miscompares++; $display("FAIL rnd_wen c=%0d got=%0b exp=%0b", c, fifo_wen, exp_wen); end
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      vectors++; if (fifo_wdata !== exp_wdata) begin miscompares++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, fifo_wdata, exp_wdata); end
      if (m_busy) begin
        vectors++; if (grant_id !== 2'(m_owner)) begin miscompares++; $display("FAIL rnd_grant c=%0d got=%0d exp=%0d", c, grant_id, m_owner); end
      end
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[(m_last + k) % N]) begin
            found = 1; m_owner = (m_last + k) % N;
          end
        end
        if (found) begin m_busy = 1; m_beats = 0; end
      end else if (exp_wen) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == BM) begin
          m_busy = 0; m_last = m_owner;
        end
      end
      step();
    end
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    #1;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_owner_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
